// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: pipelined instruction fetch unit.
//   Keeps up to MAX_OUTST AXI-lite read requests in flight to imem, picks the
//   32-bit instruction lane out of each read beat, and buffers the results in
//   an INST_Q-deep FIFO that drains to the IDU over valid/ready.
//   Redirects (interrupt has priority over jump) flush the FIFO and count the
//   responses still owed by imem so they can be discarded when they arrive.
// Ports:
//   clk, rst               clock (rising edge), async active-low reset
//   isIntrPC/IntrPC        interrupt redirect request and target
//   is_jump/JumpPc         jump redirect request and target
//   pipeline_hold          stall: blocks new issue and FIFO pop
//   ARVALID/ARADDR/ARREADY read address channel (registered)
//   RVALID/RREADY/inst_i/RRESP read data channel (RREADY tied high)
//   inst_o/pc_o/fault_o    FIFO head entry (zero while FIFO empty)
//   ifu_valid/id_ready     handshake towards IDU
module ifu_fetch_queue #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 64,
  parameter int          PC_W      = 64,
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter int          MAX_OUTST = 2,
  parameter int          INST_Q    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isIntrPC,
  input  logic [PC_W-1:0]   IntrPC,
  input  logic              is_jump,
  input  logic [PC_W-1:0]   JumpPc,
  input  logic              pipeline_hold,
  output logic              ARVALID,
  output logic [ADDR_W-1:0] ARADDR,
  input  logic              ARREADY,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] inst_i,
  input  logic [1:0]        RRESP,
  output logic [31:0]       inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              fault_o,
  output logic              ifu_valid,
  input  logic              id_ready
);
  localparam int NLANE = DATA_W / 32;
  localparam int LB    = $clog2(DATA_W / 8);
  localparam int QPW   = (INST_Q > 1) ? $clog2(INST_Q) : 1;
  localparam int PPW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW    = $clog2(INST_Q + MAX_OUTST + 1);

  typedef struct packed {
    logic [31:0]   inst;
    logic [PC_W-1:0] pc;
    logic          fault;
  } qent_t;

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              stale_q, stale_d;   // pending AR was issued before a redirect
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [QPW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [PPW-1:0]    pwp_q, pwp_d, prp_q, prp_d;

  qent_t           q_mem    [INST_Q];
  logic [PC_W-1:0] pend_mem [MAX_OUTST];

  logic            redirect, ar_fire, r_fire, enq, deq;
  logic [PC_W-1:0] tgt, head_pc;
  logic [31:0]     rsp_inst;
  qent_t           head;

  assign redirect = isIntrPC | is_jump;
  assign tgt      = isIntrPC ? IntrPC : JumpPc;
  assign ar_fire  = arvalid_q & ARREADY;
  // A beat with nothing outstanding cannot belong to us.
  assign r_fire   = RVALID & (outst_q != '0);
  assign head_pc  = pend_mem[prp_q];
  assign enq      = r_fire & (drop_q == '0) & ~redirect;
  assign ifu_valid = (cnt_q != '0) & ~pipeline_hold;
  assign deq      = ifu_valid & id_ready;

  generate
    if (NLANE == 1) begin : g_one_lane
      assign rsp_inst = inst_i[31:0];
    end else begin : g_lanes
      logic [NLANE-1:0][31:0] lanes;
      assign lanes    = inst_i;
      assign rsp_inst = lanes[head_pc[LB-1:2]];
    end
  endgenerate

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    arvalid_d  = 1'b0;
    araddr_d   = araddr_q;
    stale_d    = stale_q & ~ar_fire;
    outst_d    = outst_q + CW'(ar_fire) - CW'(r_fire);
    drop_d     = drop_q - CW'(r_fire && (drop_q != '0)) + CW'(ar_fire & stale_q);
    cnt_d      = cnt_q + CW'(enq) - CW'(deq);
    wp_d       = enq ? ((wp_q == QPW'(INST_Q - 1)) ? '0 : wp_q + QPW'(1)) : wp_q;
    rp_d       = deq ? ((rp_q == QPW'(INST_Q - 1)) ? '0 : rp_q + QPW'(1)) : rp_q;
    pwp_d      = ar_fire ? ((pwp_q == PPW'(MAX_OUTST - 1)) ? '0 : pwp_q + PPW'(1)) : pwp_q;
    prp_d      = r_fire  ? ((prp_q == PPW'(MAX_OUTST - 1)) ? '0 : prp_q + PPW'(1)) : prp_q;

    // A stale AR completing must not advance the redirected PC.
    if (ar_fire && !stale_q) fetch_pc_d = fetch_pc_q + PC_W'(4);

    if (redirect) begin
      fetch_pc_d = tgt;
      drop_d     = outst_d;                  // everything still owed after this edge
      stale_d    = arvalid_q & ~ARREADY;     // counted into drop once accepted
      cnt_d      = '0;
      wp_d       = '0;
      rp_d       = '0;
    end

    if (arvalid_q && !ARREADY) begin
      arvalid_d = 1'b1;                      // AXI: hold address until accepted
    end else if (!pipeline_hold && !redirect && (outst_d < CW'(MAX_OUTST)) &&
                 ((cnt_d + outst_d - drop_d) < CW'(INST_Q))) begin
      arvalid_d = 1'b1;
      araddr_d  = fetch_pc_d[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= PC_W'(RESET_PC);
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      stale_q    <= 1'b0;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      pwp_q      <= '0;
      prp_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      stale_q    <= stale_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      pwp_q      <= pwp_d;
      prp_q      <= prp_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (enq)     q_mem[wp_q]     <= '{inst: rsp_inst, pc: head_pc, fault: |RRESP};
    if (ar_fire) pend_mem[pwp_q] <= fetch_pc_q;
  end

  assign head    = q_mem[rp_q];
  assign inst_o  = (cnt_q != '0) ? head.inst  : '0;
  assign pc_o    = (cnt_q != '0) ? head.pc    : '0;
  assign fault_o = (cnt_q != '0) ? head.fault : 1'b0;
  assign ARVALID = arvalid_q;
  assign ARADDR  = araddr_q;
  assign RREADY  = 1'b1;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;
  localparam int MAXO = 2;
  localparam int IQ   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        isIntrPC, is_jump, pipeline_hold, ARREADY, RVALID, id_ready;
  logic [63:0] IntrPC, JumpPc;
  logic        ARVALID, RREADY, fault_o, ifu_valid;
  logic [31:0] ARADDR, inst_o;
  logic [63:0] inst_i, pc_o;
  logic [1:0]  RRESP;

  ifu_fetch_queue dut (
    .clk(clk), .rst(rst), .isIntrPC(isIntrPC), .IntrPC(IntrPC), .is_jump(is_jump),
    .JumpPc(JumpPc), .pipeline_hold(pipeline_hold), .ARVALID(ARVALID), .ARADDR(ARADDR),
    .ARREADY(ARREADY), .RVALID(RVALID), .RREADY(RREADY), .inst_i(inst_i), .RRESP(RRESP),
    .inst_o(inst_o), .pc_o(pc_o), .fault_o(fault_o), .ifu_valid(ifu_valid), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic [63:0] pc; logic fault; } ent_t;
  typedef struct { logic [31:0] a; int rdy; } mreq_t;

  // behavioural model state
  ent_t        mq[$];
  logic [63:0] mpend[$];
  int          mdrop;
  bit          mstale, marv;
  logic [63:0] mpc;
  logic [31:0] maddr;
  ent_t        dlog[$];
  mreq_t       memq[$];

  int checks = 0, failures = 0, cyc = 0;
  int rdy_pct, rv_pct, idr_pct, hold_pct, fault_pct, redir_pct;
  logic [31:0] fault_addr;

  function automatic logic [31:0] wordval(logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h0123_4567;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_log(string name, int idx, logic [63:0] pc, logic fault);
    checks++;
    if (idx >= dlog.size()) begin
      failures++;
      $display("FAIL %s cycle=%0d got=no_entry want=pc %h", name, cyc, pc);
    end else if (dlog[idx].pc !== pc || dlog[idx].fault !== fault) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h/%b want=%h/%b", name, cyc, dlog[idx].pc,
               dlog[idx].fault, pc, fault);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mpend.delete(); memq.delete();
    mdrop = 0; mstale = 0; marv = 0; maddr = '0; mpc = 64'h8000_0000;
  endtask

  task automatic set_knobs(int r, int v, int i, int h);
    rdy_pct = r; rv_pct = v; idr_pct = i; hold_pct = h;
  endtask

  // imem + IDU behaviour for one cycle; memory answers in order, >=1 cycle after accept
  task automatic drive();
    logic [31:0] a, base;
    ARREADY       = ($urandom_range(0, 99) < rdy_pct);
    id_ready      = ($urandom_range(0, 99) < idr_pct);
    pipeline_hold = ($urandom_range(0, 99) < hold_pct);
    if (ARVALID && ARREADY) memq.push_back('{ARADDR, cyc + 1});
    if (memq.size() > 0 && memq[0].rdy <= cyc && $urandom_range(0, 99) < rv_pct) begin
      a = memq[0].a;
      memq.pop_front();
      base   = {a[31:3], 3'b000};
      RVALID = 1'b1;
      inst_i = {wordval(base + 32'd4), wordval(base)};
      RRESP  = (a == fault_addr || $urandom_range(0, 99) < fault_pct) ? 2'b10 : 2'b00;
    end else begin
      RVALID = 1'b0;
      inst_i = {$urandom, $urandom};
      RRESP  = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic check_outputs();
    bit ev;
    chk("arvalid", ARVALID, marv);
    if (marv) chk("araddr", ARADDR, maddr);
    ev = (mq.size() > 0) && !pipeline_hold;
    chk("ifu_valid", ifu_valid, ev);
    if (ev) begin
      chk("inst_o", inst_o, mq[0].inst);
      chk("pc_o", pc_o, mq[0].pc);
      chk("fault_o", fault_o, mq[0].fault);
    end
  endtask

  // next state of the fetch queue from the rules, using plain queues and counts
  task automatic model_update();
    bit redirect, ar_fire, r_fire, pop;
    logic [63:0] tgt, p;
    redirect = isIntrPC || is_jump;
    tgt      = isIntrPC ? IntrPC : JumpPc;
    ar_fire  = marv && ARREADY;
    r_fire   = RVALID && (mpend.size() > 0);
    pop      = (mq.size() > 0) && !pipeline_hold && id_ready;
    if (pop) begin
      dlog.push_back(mq[0]);
      mq.pop_front();
    end
    if (r_fire) begin
      p = mpend.pop_front();
      if (mdrop > 0) mdrop--;
      else if (!redirect) mq.push_back('{wordval(p[31:0]), p, RRESP != 2'b00});
    end
    if (ar_fire) begin
      mpend.push_back(mpc);
      if (mstale) begin mdrop++; mstale = 0; end
      else mpc += 64'd4;
    end
    if (redirect) begin
      mq.delete();
      mpc    = tgt;
      mdrop  = mpend.size();
      mstale = marv && !ARREADY;
    end
    if (marv && !ARREADY) begin
      // address stays stable
    end else if (!pipeline_hold && !redirect && mpend.size() < MAXO &&
                 (mq.size() + mpend.size() - mdrop) < IQ) begin
      marv = 1; maddr = mpc[31:0];
    end else begin
      marv = 0;
    end
  endtask

  task automatic step();
    drive();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int n0;
    logic [31:0] a0;
    rst = 1'b0; isIntrPC = 0; is_jump = 0; IntrPC = '0; JumpPc = '0;
    pipeline_hold = 0; ARREADY = 0; RVALID = 0; id_ready = 0; inst_i = '0; RRESP = '0;
    fault_addr = '0; fault_pct = 0; redir_pct = 0;
    model_reset();
    #2;
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_ifu_valid", ifu_valid, 0);
    chk("rst_inst_o", inst_o, 0);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_fault_o", fault_o, 0);
    chk("rready", RREADY, 1);
    @(negedge clk);
    rst = 1'b1;

    // streaming, 1-cycle memory, IDU always ready
    set_knobs(100, 100, 100, 0);
    step();
    chk("first_arvalid", ARVALID, 1);
    chk("first_araddr", ARADDR, 32'h8000_0000);
    repeat (12) step();
    checks++;
    if (dlog.size() < 3) begin
      failures++;
      $display("FAIL stream_count cycle=%0d got=%0d want>=3", cyc, dlog.size());
    end else chk("stream_inst0", dlog[0].inst, 32'h8123_4567);
    chk_log("stream_pc1", 1, 64'h8000_0004, 0);
    chk_log("stream_pc2", 2, 64'h8000_0008, 0);

    // IDU stalled: FIFO fills exactly, issue stops
    set_knobs(100, 100, 0, 0);
    repeat (10) step();
    chk("full_count", mq.size(), IQ);
    chk("full_outst", mpend.size(), 0);
    chk("full_arvalid", ARVALID, 0);
    set_knobs(100, 100, 100, 0);
    repeat (12) step();
    for (int i = 0; i < dlog.size(); i++)
      chk_log("no_loss", i, 64'h8000_0000 + 64'(4 * i), 0);

    // jump redirect while streaming
    is_jump = 1; JumpPc = 64'h8000_1000;
    step();
    is_jump = 0;
    n0 = dlog.size();
    for (int k = 0; k < 10 && !ARVALID; k++) step();
    chk("jump_arvalid", ARVALID, 1);
    chk("jump_araddr", ARADDR, 32'h8000_1000);
    repeat (8) step();
    chk_log("jump_first_pc", n0, 64'h8000_1000, 0);

    // simultaneous interrupt and jump while AR is stalled
    set_knobs(0, 100, 100, 0);
    repeat (5) step();
    chk("stall_arvalid", ARVALID, 1);
    a0 = ARADDR;
    isIntrPC = 1; IntrPC = 64'h8000_0100; is_jump = 1; JumpPc = 64'h8000_2000;
    step();
    isIntrPC = 0; is_jump = 0;
    repeat (3) step();
    chk("stall_hold_valid", ARVALID, 1);
    chk("stall_hold_addr", ARADDR, a0);
    n0 = dlog.size();
    set_knobs(100, 100, 100, 0);
    for (int k = 0; k < 10 && !(ARVALID && ARADDR == 32'h8000_0100); k++) step();
    chk("intr_araddr", ARADDR, 32'h8000_0100);
    repeat (8) step();
    chk_log("intr_first_pc", n0, 64'h8000_0100, 0);

    // async reset mid-burst, late response, restart with a faulting beat
    repeat (3) step();
    #3 rst = 1'b0;
    #1;
    chk("arst_arvalid", ARVALID, 0);
    chk("arst_ifu_valid", ifu_valid, 0);
    model_reset();
    memq.push_back('{32'h8000_0040, 0});   // response owed from before reset
    @(negedge clk);
    rst = 1'b1;
    fault_addr = 32'h8000_0004;
    set_knobs(0, 100, 100, 0);
    step();
    chk("restart_araddr", ARADDR, 32'h8000_0000);
    set_knobs(100, 100, 100, 0);
    n0 = dlog.size();
    repeat (12) step();
    chk_log("restart_pc0", n0,     64'h8000_0000, 0);
    chk_log("fault_pc1",   n0 + 1, 64'h8000_0004, 1);
    chk_log("restart_pc2", n0 + 2, 64'h8000_0008, 0);
    fault_addr = '0;

    // randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs($urandom_range(20, 100), $urandom_range(20, 100),
                $urandom_range(10, 100), $urandom_range(0, 25));
      fault_pct = 5;
      redir_pct = $urandom_range(0, 6);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 99) < redir_pct) begin
          isIntrPC = $urandom_range(0, 1);
          is_jump  = !isIntrPC || ($urandom_range(0, 1) == 1);
          IntrPC   = 64'h8000_0000 + 64'($urandom_range(0, 1023) * 4);
          JumpPc   = 64'h8000_0000 + 64'($urandom_range(0, 1023) * 4);
        end
        step();
        isIntrPC = 0; is_jump = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
